// File: rtl/stopwatch_count_if.sv
// stopwatch_count_if: control inputs and BCD digit outputs of the stopwatch core.
// With `define ADJUST_BLINK_EN a blink signal is added.
interface stopwatch_count_if;
  logic       pause;
  logic [1:0] adjust;
  logic       select;
  logic [3:0] min1, min0, sec1, sec0;
`ifdef ADJUST_BLINK_EN
  logic       blink;
  modport master (output pause, adjust, select, input min1, min0, sec1, sec0, blink);
  modport slave (input pause, adjust, select, output min1, min0, sec1, sec0, blink);
`else
  modport master (output pause, adjust, select, input min1, min0, sec1, sec0);
  modport slave (input pause, adjust, select, output min1, min0, sec1, sec0);
`endif
endinterface

// File: rtl/stopwatch_count.sv
// stopwatch_count: MM:SS BCD stopwatch with prescaler, pause and per-field adjust.
// `define ADJUST_BLINK_EN adds a blink output for blanking the field being adjusted.
module stopwatch_count #(
  parameter int TICK_DIV = 100000000
) (
  input logic clk,
  input logic reset,
  stopwatch_count_if.slave sw
);
  localparam int QDIV = TICK_DIV / 4;
  localparam int QW = QDIV > 1 ? $clog2(QDIV) : 1;
  logic [QW-1:0] qcnt;
  logic [1:0] phase;
  logic [3:0] min1, min0, sec1, sec0;
  logic qtick, tick1, tick_adj, sec_en, min_en;
  logic [7:0] sec_nxt, min_nxt;
  function automatic logic [7:0] inc59(input logic [3:0] t, input logic [3:0] o);
    return o == 4'd9 ? (t == 4'd5 ? 8'h00 : {t + 4'd1, 4'd0}) : {t, o + 4'd1};
  endfunction
  always_comb begin
    qtick = !sw.pause && qcnt == QW'(QDIV - 1);
    tick1 = qtick && phase == 2'd3;
    tick_adj = qtick && (sw.adjust[1] || phase[0]);
    sec_en = sw.adjust[0] ? tick_adj && sw.select : tick1;
    min_en = sw.adjust[0] ? tick_adj && !sw.select : tick1 && sec1 == 4'd5 && sec0 == 4'd9;
    sec_nxt = inc59(sec1, sec0);
    min_nxt = inc59(min1, min0);
  end
  always_ff @(posedge clk)
    if (reset) begin
      qcnt <= '0;
      phase <= '0;
      {min1, min0, sec1, sec0} <= '0;
    end else begin
      if (!sw.pause) qcnt <= qtick ? '0 : qcnt + 1'b1;
      if (qtick) phase <= phase + 2'd1;
      if (sec_en) {sec1, sec0} <= sec_nxt;
      if (min_en) {min1, min0} <= min_nxt;
    end
  assign sw.min1 = min1;
  assign sw.min0 = min0;
  assign sw.sec1 = sec1;
  assign sw.sec0 = sec0;
`ifdef ADJUST_BLINK_EN
  assign sw.blink = sw.adjust[0] && phase[1];
`endif
endmodule

// File: tb/tb_stopwatch_count.sv
// tb_stopwatch_count: randomized self-checking bench against a seconds/minutes model.
module tb_stopwatch_count;
  localparam int TD = 8;
  logic clk = 0;
  logic reset = 1;
  int tests = 0, fails = 0;
  int k = 0, m = 0, s = 0;
  stopwatch_count_if sw ();
  stopwatch_count #(.TICK_DIV(TD)) dut (.clk(clk), .reset(reset), .sw(sw));
  always #5 clk = ~clk;
  function automatic logic [15:0] exp_d();
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic logic [15:0] got_d();
    return {sw.min1, sw.min0, sw.sec1, sw.sec0};
  endfunction
  // k counts unpaused clock edges since reset; every rate is a divisor of it
  task automatic step();
    @(posedge clk);
    if (reset) begin
      k = 0; m = 0; s = 0;
    end else if (!sw.pause) begin
      k++;
      if (sw.adjust[0]) begin
        if (k % (sw.adjust[1] ? TD / 4 : TD / 2) == 0) begin
          if (sw.select) s = (s + 1) % 60;
          else m = (m + 1) % 60;
        end
      end else if (k % TD == 0) begin
        s++;
        if (s == 60) begin s = 0; m = (m + 1) % 60; end
      end
    end
    #1;
  endtask
  task automatic test_reset();
    reset = 1; sw.pause = 0; sw.adjust = 0; sw.select = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (got_d() !== 16'h0000) begin fails++; $display("FAIL reset: got %h exp 0000", got_d()); end
    end
    reset = 0;
  endtask
  task automatic test_count();
    for (int i = 1; i <= 10 * TD; i++) begin
      step();
      tests++;
      if (got_d() !== exp_d()) begin fails++; $display("FAIL count c%0d: got %h exp %h", i, got_d(), exp_d()); end
      if (i == TD - 1 || i == TD || i == 10 * TD) begin
        tests++;
        if (got_d() !== (i == TD - 1 ? 16'h0000 : i == TD ? 16'h0001 : 16'h0010)) begin
          fails++; $display("FAIL count_fixed c%0d: got %h", i, got_d());
        end
      end
    end
  endtask
  task automatic test_rollover();
    int n;
    sw.adjust = 2'b11;
    sw.select = 1;
    n = 0;
    while (s != 59 && n < 1000) begin step(); n++; end
    sw.adjust = 0;
    n = 0;
    while (!(m == 1 && s == 1) && n < 200) begin
      step(); n++;
      tests++;
      if (got_d() !== exp_d()) begin fails++; $display("FAIL min_carry: got %h exp %h", got_d(), exp_d()); end
    end
    sw.adjust = 2'b11;
    sw.select = 0;
    n = 0;
    while (m != 59 && n < 1000) begin step(); n++; end
    sw.select = 1;
    while (s != 58 && n < 2000) begin step(); n++; end
    tests++;
    if (n >= 2000 || got_d() !== 16'h5958) begin fails++; $display("FAIL preload: got %h exp 5958", got_d()); end
    sw.adjust = 0;
    for (int i = 0; i < 2 * TD + 1; i++) begin
      step();
      tests++;
      if (got_d() !== exp_d()) begin fails++; $display("FAIL wrap: got %h exp %h", got_d(), exp_d()); end
    end
  endtask
  task automatic test_pause();
    logic [15:0] held;
    for (int i = 0; i < 3; i++) step();
    sw.pause = 1;
    held = got_d();
    for (int i = 0; i < 40; i++) begin
      step();
      tests++;
      if (got_d() !== held) begin fails++; $display("FAIL pause_hold: got %h exp %h", got_d(), held); end
    end
    sw.pause = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      step();
      tests++;
      if (got_d() !== exp_d()) begin fails++; $display("FAIL pause_resume: got %h exp %h", got_d(), exp_d()); end
    end
  endtask
  task automatic test_adjust();
    for (int r = 0; r < 4; r++) begin
      sw.adjust = {r[1], 1'b1};
      sw.select = r[0];
      for (int i = 0; i < 70 * TD; i++) begin
        step();
        tests++;
        if (got_d() !== exp_d()) begin fails++; $display("FAIL adjust%0d: got %h exp %h", r, got_d(), exp_d()); end
`ifdef ADJUST_BLINK_EN
        tests++;
        if (sw.blink !== ((k % TD) >= TD / 2)) begin fails++; $display("FAIL blink: got %b k=%0d", sw.blink, k); end
`endif
      end
    end
    sw.adjust = 0;
  endtask
  task automatic test_reset_adjust();
    sw.adjust = 2'b01; sw.pause = 1; reset = 1;
    step();
    tests++;
    if (got_d() !== 16'h0000) begin fails++; $display("FAIL reset_adjust: got %h exp 0000", got_d()); end
    reset = 0; sw.pause = 0; sw.adjust = 0;
    for (int i = 0; i < TD; i++) begin
      step();
      tests++;
      if (got_d() !== (i == TD - 1 ? 16'h0001 : 16'h0000)) begin fails++; $display("FAIL restart c%0d: got %h", i, got_d()); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        sw.pause = $urandom_range(0, 3) == 0;
        sw.adjust = 2'($urandom);
        sw.select = 1'($urandom);
      end
      reset = $urandom_range(0, 299) == 0;
      step();
      tests++;
      if (got_d() !== exp_d()) begin fails++; $display("FAIL random i%0d: got %h exp %h", i, got_d(), exp_d()); end
`ifdef ADJUST_BLINK_EN
      tests++;
      if (sw.blink !== (sw.adjust[0] && (k % TD) >= TD / 2)) begin fails++; $display("FAIL random_blink: got %b", sw.blink); end
`endif
    end
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_count();
    test_pause();
    test_rollover();
    test_adjust();
    test_reset_adjust();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
